// File: rtl/r5fp_pkg.sv
// Shared r5fp definitions: rounding modes, flag/status bit positions and
// special-value encodings used by the add/mul/mac datapaths and rounding.
package r5fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rnd_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int ST_IS_NAN  = 4;
  localparam int ST_IS_INF  = 3;
  localparam int ST_IS_ZERO = 2;
  localparam int ST_SIGN    = 1;
  localparam int ST_STICKY  = 0;

  // Encodings are returned zero-extended to 64 bits; callers slice to width.
  function automatic logic [63:0] canon_nan(input int exp_w, input int sig_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << sig_w;
    v = v | (64'd1 << (sig_w - 1));
    return v;
  endfunction

  function automatic logic [63:0] max_finite(input int exp_w, input int sig_w);
    return (((64'd1 << exp_w) - 64'd2) << sig_w) | ((64'd1 << sig_w) - 64'd1);
  endfunction

endpackage

// File: rtl/r5fp_round_core.sv
// Combinational round/overflow/pack logic: takes a denormalized significand
// with guard/round/sticky and produces the packed IEEE word plus flags.
module r5fp_round_core
  import r5fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int SIG_W = 10
) (
  input  logic                 i_sign,
  input  logic [EXP_W+1:0]     i_exp,
  input  logic [SIG_W+3:0]     i_sig,
  input  logic                 i_sticky,
  input  logic                 i_tiny,
  input  logic [2:0]           i_rnd,
  input  logic                 i_to_inf,
  input  logic                 i_is_nan,
  input  logic                 i_is_inf,
  input  logic                 i_is_zero,
  input  logic                 i_snan,
  output logic [EXP_W+SIG_W:0] o_z,
  output logic [4:0]           o_flags
);
  localparam logic [63:0]      NAN64    = canon_nan(EXP_W, SIG_W);
  localparam logic [63:0]      MAXF64   = max_finite(EXP_W, SIG_W);
  localparam logic [EXP_W+1:0] EXP_ALL1 = {2'b00, {EXP_W{1'b1}}};

  logic             w_l, w_g, w_s, w_inexact, w_inc;
  logic             w_carry, w_hidden, w_ovf, w_to_max;
  logic [SIG_W+1:0] w_sum;
  logic [EXP_W+1:0] w_exp_r;

  assign w_l       = i_sig[2];
  assign w_g       = i_sig[1];
  assign w_s       = i_sig[0] | i_sticky;
  assign w_inexact = w_g | w_s;

  always_comb begin
    w_inc = 1'b0;
    case (i_rnd)
      RM_RNE:  w_inc = w_g & (w_l | w_s);
      RM_RDN:  w_inc = i_sign & w_inexact;
      RM_RUP:  w_inc = !i_sign & w_inexact;
      RM_RMM:  w_inc = w_g;
      default: w_inc = 1'b0;
    endcase
  end

  // Subnormals carry exp=0; reaching the hidden bit promotes them to exp 1.
  assign w_sum    = i_sig[SIG_W+3:2] + {{(SIG_W+1){1'b0}}, w_inc};
  assign w_carry  = w_sum[SIG_W+1];
  assign w_hidden = w_sum[SIG_W+1] | w_sum[SIG_W];
  assign w_exp_r  = i_tiny ? {{(EXP_W+1){1'b0}}, w_hidden}
                           : i_exp + {{(EXP_W+1){1'b0}}, w_carry};
  assign w_ovf    = i_to_inf | (w_exp_r >= EXP_ALL1);
  assign w_to_max = (i_rnd == RM_RTZ) | ((i_rnd == RM_RDN) & !i_sign)
                  | ((i_rnd == RM_RUP) & i_sign);

  always_comb begin
    o_z              = {i_sign, w_exp_r[EXP_W-1:0], w_sum[SIG_W-1:0]};
    o_flags          = '0;
    o_flags[FLAG_DZ] = 1'b0;
    o_flags[FLAG_UF] = i_tiny & w_inexact;
    o_flags[FLAG_NX] = w_inexact;
    if (i_is_nan) begin
      o_z              = NAN64[EXP_W+SIG_W:0];
      o_flags          = '0;
      o_flags[FLAG_NV] = i_snan;
    end else if (i_is_inf) begin
      o_z     = {i_sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      o_flags = '0;
    end else if (i_is_zero) begin
      o_z     = {i_sign, {(EXP_W+SIG_W){1'b0}}};
      o_flags = '0;
    end else if (w_ovf) begin
      o_z              = w_to_max ? {i_sign, MAXF64[EXP_W+SIG_W-1:0]}
                                  : {i_sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      o_flags          = '0;
      o_flags[FLAG_OF] = 1'b1;
      o_flags[FLAG_NX] = 1'b1;
    end
  end

endmodule

// File: rtl/r5fp_round_pipe.sv
// Two-stage round pipeline: stage 1 denormalizes into the subnormal range,
// stage 2 rounds and packs; valid/ready with backpressure, flush and fflags.
module r5fp_round_pipe
  import r5fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int SIG_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W+1:0]     in_exp,
  input  logic [SIG_W+3:0]     in_sig,
  input  logic [4:0]           in_status,
  input  logic                 in_to_inf,
  input  logic [2:0]           in_rnd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+SIG_W:0] out_z,
  output logic [4:0]           out_flags,
  output logic [4:0]           fflags,
  input  logic                 fflags_clr
);
  localparam int XW = EXP_W + 2;
  localparam int SW = SIG_W + 4;

  typedef struct packed {
    logic          sign;
    logic [XW-1:0] exp;
    logic [SW-1:0] sig;
    logic          sticky;
    logic          tiny;
    logic [2:0]    rnd;
    logic          to_inf;
    logic          is_nan;
    logic          is_inf;
    logic          is_zero;
    logic          snan;
  } s1_t;

  s1_t                  r_s1, w_s1_d;
  logic                 r_s1_valid, r_s2_valid;
  logic [EXP_W+SIG_W:0] r_z, w_z;
  logic [4:0]           r_flags, w_flags, r_fflags;
  logic                 w_s1_ready, w_s2_ready, w_out_hs, w_tiny, w_unused_sign;
  logic [XW:0]          w_shamt;
  logic [SW-1:0]        w_mask;

  assign w_s2_ready    = !r_s2_valid | out_ready;
  assign w_s1_ready    = !r_s1_valid | w_s2_ready;
  assign in_ready      = w_s1_ready;
  assign out_valid     = r_s2_valid;
  assign out_z         = r_z;
  assign out_flags     = r_flags;
  assign fflags        = r_fflags;
  assign w_out_hs      = r_s2_valid & out_ready;
  assign w_unused_sign = in_status[ST_SIGN];

  // Shift amounts past the significand width shift everything into the mask.
  assign w_tiny  = in_exp[XW-1] | (in_exp == '0);
  assign w_shamt = {{XW{1'b0}}, 1'b1} - {in_exp[XW-1], in_exp};
  assign w_mask  = ~({SW{1'b1}} << w_shamt);

  always_comb begin
    w_s1_d         = '0;
    w_s1_d.sign    = in_sign;
    w_s1_d.exp     = w_tiny ? '0 : in_exp;
    w_s1_d.sig     = w_tiny ? (in_sig >> w_shamt) : in_sig;
    w_s1_d.sticky  = in_status[ST_STICKY] | (w_tiny & |(in_sig & w_mask));
    w_s1_d.tiny    = w_tiny;
    w_s1_d.rnd     = in_rnd;
    w_s1_d.to_inf  = in_to_inf;
    w_s1_d.is_nan  = in_status[ST_IS_NAN];
    w_s1_d.is_inf  = in_status[ST_IS_INF];
    w_s1_d.is_zero = in_status[ST_IS_ZERO];
    w_s1_d.snan    = in_sig[SIG_W+1];
  end

  r5fp_round_core #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_core (
    .i_sign    (r_s1.sign),
    .i_exp     (r_s1.exp),
    .i_sig     (r_s1.sig),
    .i_sticky  (r_s1.sticky),
    .i_tiny    (r_s1.tiny),
    .i_rnd     (r_s1.rnd),
    .i_to_inf  (r_s1.to_inf),
    .i_is_nan  (r_s1.is_nan),
    .i_is_inf  (r_s1.is_inf),
    .i_is_zero (r_s1.is_zero),
    .i_snan    (r_s1.snan),
    .o_z       (w_z),
    .o_flags   (w_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1       <= '0;
      r_z        <= '0;
      r_flags    <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) r_s1 <= w_s1_d;
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_z     <= w_z;
          r_flags <= w_flags;
        end
      end
    end
  end

  // A clear coinciding with a handshake still keeps the new result's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fflags <= '0;
    end else if (w_out_hs) begin
      r_fflags <= (fflags_clr ? 5'b0 : r_fflags) | r_flags;
    end else if (fflags_clr) begin
      r_fflags <= '0;
    end
  end

endmodule

// File: tb/tb_r5fp_round_pipe.sv
// Directed bench for r5fp_round_pipe: expected results queued on input
// handshake and compared on output handshake, plus pipeline-control checks.
module tb_r5fp_round_pipe;
  import r5fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_sign, in_to_inf;
  logic        out_valid, out_ready, fflags_clr;
  logic [6:0]  in_exp;
  logic [13:0] in_sig;
  logic [4:0]  in_status, out_flags, fflags;
  logic [2:0]  in_rnd;
  logic [15:0] out_z;

  typedef struct packed {
    logic [15:0] z;
    logic [4:0]  f;
  } exp_t;

  exp_t       sb[$];
  exp_t       exp_in, mon_e;
  logic [4:0] ff_model = '0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  r5fp_round_pipe #(.EXP_W(5), .SIG_W(10)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
    .in_status(in_status), .in_to_inf(in_to_inf), .in_rnd(in_rnd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags),
    .fflags(fflags), .fflags_clr(fflags_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard and fflags model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      ff_model = '0;
    end else begin
      chk("fflags", {27'b0, fflags}, {27'b0, ff_model});
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {31'b0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          $display("out z=%h flags=%b (want %h %b)", out_z, out_flags, mon_e.z, mon_e.f);
          chk("out_z", {16'b0, out_z}, {16'b0, mon_e.z});
          chk("out_flags", {27'b0, out_flags}, {27'b0, mon_e.f});
          ff_model = (fflags_clr ? 5'b0 : ff_model) | mon_e.f;
        end
      end else if (fflags_clr) begin
        ff_model = '0;
      end
      if (in_valid && in_ready && !flush) sb.push_back(exp_in);
    end
  end

  task automatic set_in(input logic s, input logic [6:0] e, input logic [13:0] sg,
                        input logic [4:0] st, input logic ti, input logic [2:0] rm,
                        input logic [15:0] z, input logic [4:0] f);
    in_sign   = s;
    in_exp    = e;
    in_sig    = sg;
    in_status = st;
    in_to_inf = ti;
    in_rnd    = rm;
    exp_in    = '{z: z, f: f};
    in_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [6:0] e, input logic [13:0] sg,
                      input logic [4:0] st, input logic ti, input logic [2:0] rm,
                      input logic [15:0] z, input logic [4:0] f);
    set_in(s, e, sg, st, ti, rm, z, f);
    wait_accept();
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic latency_test();
    set_in(1'b0, 7'd15, 14'h1006, 5'b00000, 1'b0, RM_RNE, 16'h3C02, 5'b00001);
    @(negedge clk);
    chk("lat_hs", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_n2", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_sig = '0; in_status = '0; in_to_inf = 1'b0;
    in_rnd = '0; exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_z", {16'b0, out_z}, 32'd0);
    chk("rst_out_flags", {27'b0, out_flags}, 32'd0);
    chk("rst_fflags", {27'b0, fflags}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-throughput directed results
    send(0, 7'd15,  14'h1006, 5'b00000, 0, RM_RNE, 16'h3C02, 5'b00001);
    send(0, 7'd15,  14'h1006, 5'b00000, 0, RM_RTZ, 16'h3C01, 5'b00001);
    send(0, 7'd30,  14'h1FFE, 5'b00000, 0, RM_RNE, 16'h7C00, 5'b00101);
    send(0, 7'd30,  14'h1FFE, 5'b00000, 0, RM_RTZ, 16'h7BFF, 5'b00001);
    send(0, 7'd30,  14'h1FFE, 5'b00000, 1, RM_RDN, 16'h7BFF, 5'b00101);
    send(1, 7'd30,  14'h1FFE, 5'b00000, 0, RM_RDN, 16'hFC00, 5'b00101);
    send(1, 7'd30,  14'h1FFE, 5'b00000, 1, RM_RUP, 16'hFBFF, 5'b00101);
    send(0, 7'd0,   14'h1000, 5'b00000, 0, RM_RNE, 16'h0200, 5'b00000);
    send(0, 7'h77,  14'h1000, 5'b00000, 0, RM_RNE, 16'h0001, 5'b00000);
    send(0, 7'h76,  14'h1000, 5'b00000, 0, RM_RNE, 16'h0000, 5'b00011);
    send(0, 7'h76,  14'h1000, 5'b00000, 0, RM_RUP, 16'h0001, 5'b00011);
    send(0, 7'h58,  14'h1000, 5'b00000, 0, RM_RUP, 16'h0001, 5'b00011);
    send(0, 7'd0,   14'h1FFE, 5'b00000, 0, RM_RNE, 16'h0400, 5'b00011);
    send(0, 7'd15,  14'h1002, 5'b00000, 0, RM_RMM, 16'h3C01, 5'b00001);
    send(0, 7'd15,  14'h1002, 5'b00000, 0, RM_RNE, 16'h3C00, 5'b00001);
    send(0, 7'd15,  14'h1004, 5'b00001, 0, RM_RUP, 16'h3C02, 5'b00001);
    send(1, 7'd15,  14'h1000, 5'b01000, 0, RM_RNE, 16'hFC00, 5'b00000);
    send(1, 7'd15,  14'h1000, 5'b00100, 0, RM_RNE, 16'h8000, 5'b00000);
    send(0, 7'd15,  14'h1000, 5'b10000, 0, RM_RNE, 16'h7E00, 5'b00000);
    in_valid = 1'b0;
    drain();

    // Signalling NaN and the flag accumulator
    fflags_clr = 1'b1;
    @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    send(0, 7'd15, 14'h0800, 5'b10000, 0, RM_RNE, 16'h7E00, 5'b10000);
    in_valid = 1'b0;
    drain();
    chk("fflags_nan", {27'b0, fflags}, 32'b10000);
    fflags_clr = 1'b1;
    @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    chk("fflags_clr", {27'b0, fflags}, 32'd0);

    // Backpressure: two accepted, third held until the output drains
    out_ready = 1'b0;
    send(0, 7'd15, 14'h1006, 5'b00000, 0, RM_RNE, 16'h3C02, 5'b00001);
    send(1, 7'd15, 14'h1000, 5'b00100, 0, RM_RNE, 16'h8000, 5'b00000);
    set_in(0, 7'd15, 14'h1002, 5'b00000, 0, RM_RMM, 16'h3C01, 5'b00001);
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_z", {16'b0, out_z}, 32'h3C02);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    drain();

    // Flush with two entries in flight
    out_ready = 1'b0;
    send(0, 7'd30, 14'h1FFE, 5'b00000, 0, RM_RTZ, 16'h7BFF, 5'b00001);
    send(0, 7'd0,  14'h1000, 5'b00000, 0, RM_RNE, 16'h0200, 5'b00000);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    latency_test();

    // Asynchronous reset with two entries in flight
    out_ready = 1'b0;
    send(0, 7'd30, 14'h1FFE, 5'b00000, 0, RM_RNE, 16'h7C00, 5'b00101);
    send(0, 7'h77, 14'h1000, 5'b00000, 0, RM_RNE, 16'h0001, 5'b00000);
    in_valid = 1'b0;
    #1;
    chk("rst_pre_valid", {31'b0, out_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    latency_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
